// File: rtl/me_product_acc.sv
// rtl/me_product_acc.sv - streaming product accumulator over FIFO operands with an external multiplier
module me_product_acc #(
  parameter int WIDTH = 3072,
  parameter int CNT_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_pre_me,
  input  logic             scanning_e,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             rd_fifo,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic             mul_start,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_res,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic [CNT_W-1:0] n_ops
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    FETCH    = 3'd2,
    MUL_WAIT = 3'd3,
    FLUSH    = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] N_MAX = '1;
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_n;
  logic [WIDTH-1:0] acc;
  logic             acc_valid;
  logic             drain_seen;
  logic             do_clear;
  logic             load_first;
  logic             load_mul;
  logic             take_prod;
  logic             enter_done;
  logic [CNT_W-1:0] n_ops_inc;

  assign n_ops_inc = (n_ops == N_MAX) ? n_ops : n_ops + 1'b1;

  // State register; reset always lands in IDLE regardless of any multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and control strobes; a start pulse always takes priority over progress.
  always_comb begin
    state_n    = state;
    do_clear   = 1'b0;
    load_first = 1'b0;
    load_mul   = 1'b0;
    take_prod  = 1'b0;
    enter_done = 1'b0;
    rd_fifo    = 1'b0;
    busy       = (state != IDLE) && (state != DONE);
    case (state)
      IDLE, DONE: begin
        if (en_pre_me) begin
          state_n  = COLLECT;
          do_clear = 1'b1;
        end
      end
      COLLECT: begin
        if (en_pre_me) begin
          state_n  = COLLECT;
          do_clear = 1'b1;
        end else if (!fifo_empty) begin
          rd_fifo = 1'b1;
          state_n = FETCH;
        end else if (!scanning_e && drain_seen) begin
          state_n    = DONE;
          enter_done = 1'b1;
        end
      end
      FETCH: begin
        if (en_pre_me) begin
          state_n  = COLLECT;
          do_clear = 1'b1;
        end else if (!acc_valid) begin
          load_first = 1'b1;
          state_n    = COLLECT;
        end else begin
          load_mul = 1'b1;
          state_n  = MUL_WAIT;
        end
      end
      MUL_WAIT: begin
        if (en_pre_me) begin
          // A restart coinciding with completion needs no flush: nothing is left in flight.
          if (mul_done) begin
            state_n  = COLLECT;
            do_clear = 1'b1;
          end else begin
            state_n = FLUSH;
          end
        end else if (mul_done) begin
          take_prod = 1'b1;
          state_n   = COLLECT;
        end
      end
      FLUSH: begin
        if (mul_done) begin
          state_n  = COLLECT;
          do_clear = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (rst) rd_fifo = 1'b0;
  end

  // Termination needs two consecutive quiet COLLECT cycles so a word written as the scanner stops is not lost.
  always_ff @(posedge clk) begin
    if (rst) drain_seen <= 1'b0;
    else     drain_seen <= (state == COLLECT) && !en_pre_me && fifo_empty && !scanning_e;
  end

  // Datapath: accumulator, multiplier operands, operand count and published result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      acc_valid    <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      mul_start    <= 1'b0;
      n_ops        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      mul_start <= load_mul;
      if (do_clear) begin
        acc          <= '0;
        acc_valid    <= 1'b0;
        n_ops        <= '0;
        result_valid <= 1'b0;
      end
      if (load_first) begin
        acc       <= fifo_dout;
        acc_valid <= 1'b1;
        n_ops     <= n_ops_inc;
      end
      if (load_mul) begin
        mul_a <= acc;
        mul_b <= fifo_dout;
        n_ops <= n_ops_inc;
      end
      if (take_prod) acc <= mul_res;
      if (enter_done) begin
        result       <= acc_valid ? acc : ONE;
        result_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_me_product_acc.sv
// tb/tb_me_product_acc.sv - directed self-checking bench for me_product_acc
module tb_me_product_acc;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en_pre_me = 1'b0;
  logic          scanning_e = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_dout = '0;
  logic          rd_fifo;
  logic [W-1:0]  mul_a, mul_b;
  logic          mul_start;
  logic          mul_done;
  logic [W-1:0]  mul_res;
  logic [W-1:0]  result;
  logic          result_valid, busy;
  logic [CW-1:0] n_ops;

  logic          push_en = 1'b0;
  logic [W-1:0]  push_data = '0;
  logic          model_done = 1'b0;
  logic          force_done = 1'b0;
  logic [W-1:0]  prod = '0;
  int            mcnt = 0;
  logic [W-1:0]  fifo_q[$];

  int rd_cnt = 0, rd_bad = 0, ms_cnt = 0, overlap = 0, lat_bad = 0, cyc = 0, last_rd = -100;
  int n_checks = 0, n_fail = 0;

  assign mul_done = model_done | force_done;
  assign mul_res  = prod;

  always #5 clk = ~clk;

  me_product_acc #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en_pre_me(en_pre_me), .scanning_e(scanning_e),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .rd_fifo(rd_fifo),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_done(mul_done),
    .mul_res(mul_res), .result(result), .result_valid(result_valid),
    .busy(busy), .n_ops(n_ops)
  );

  // FIFO model, 4-cycle multiplier model and protocol monitors.
  always @(posedge clk) begin
    if (mul_start) begin
      ms_cnt++;
      if (mcnt != 0) overlap++;
      if (cyc - last_rd != 2) lat_bad++;
    end
    if (rd_fifo) begin
      rd_cnt++;
      if (fifo_empty) rd_bad++;
      if (fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
      last_rd = cyc;
    end
    if (push_en) fifo_q.push_back(push_data);
    fifo_empty <= (fifo_q.size() == 0);
    model_done <= 1'b0;
    if (mul_start) begin
      mcnt <= 4;
      prod <= mul_a * mul_b;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) model_done <= 1'b1;
    end
    cyc++;
  end

  task automatic push_word(input logic [W-1:0] w);
    push_en = 1'b1; push_data = w;
    @(negedge clk);
    push_en = 1'b0;
  endtask

  task automatic pulse_start();
    en_pre_me = 1'b1;
    @(negedge clk);
    en_pre_me = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cycles);
    cycles = 1;
    while (!result_valid && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_result_valid got %b want 0", result_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (result !== '0 || n_ops !== '0) begin n_fail++; $display("FAIL reset_result_nops got %0d/%0d want 0/0", result, n_ops); end
    n_checks++; if (rd_fifo !== 1'b0 || mul_start !== 1'b0 || mul_a !== '0 || mul_b !== '0) begin n_fail++; $display("FAIL reset_strobes got rd=%b ms=%b a=%0d b=%0d want 0", rd_fifo, mul_start, mul_a, mul_b); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_empty();
    int c; int rd0; int ms0;
    rd0 = rd_cnt; ms0 = ms_cnt;
    scanning_e = 1'b0;
    pulse_start();
    wait_done(50, c);
    n_checks++; if (c !== 3) begin n_fail++; $display("FAIL empty_latency got %0d want 3", c); end
    n_checks++; if (result !== 32'd1 || result_valid !== 1'b1) begin n_fail++; $display("FAIL empty_result got %0d v=%b want 1 v=1", result, result_valid); end
    n_checks++; if (n_ops !== 4'd0) begin n_fail++; $display("FAIL empty_nops got %0d want 0", n_ops); end
    n_checks++; if (rd_cnt - rd0 !== 0 || ms_cnt - ms0 !== 0) begin n_fail++; $display("FAIL empty_strobes got rd=%0d ms=%0d want 0/0", rd_cnt - rd0, ms_cnt - ms0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    int c; int rd0; int ms0;
    rd0 = rd_cnt; ms0 = ms_cnt;
    scanning_e = 1'b1;
    pulse_start();
    n_checks++; if (result_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_start got v=%b busy=%b want 0/1", result_valid, busy); end
    push_word(32'd5);
    repeat (3) @(negedge clk);
    scanning_e = 1'b0;
    wait_done(50, c);
    n_checks++; if (result !== 32'd5 || result_valid !== 1'b1) begin n_fail++; $display("FAIL single_result got %0d v=%b want 5 v=1", result, result_valid); end
    n_checks++; if (n_ops !== 4'd1) begin n_fail++; $display("FAIL single_nops got %0d want 1", n_ops); end
    n_checks++; if (rd_cnt - rd0 !== 1 || ms_cnt - ms0 !== 0) begin n_fail++; $display("FAIL single_strobes got rd=%0d ms=%0d want 1/0", rd_cnt - rd0, ms_cnt - ms0); end
  endtask

  task automatic test_three();
    int c; int rd0; int ms0;
    rd0 = rd_cnt; ms0 = ms_cnt;
    scanning_e = 1'b0;
    push_word(32'd3); push_word(32'd7); push_word(32'd11);
    pulse_start();
    wait_done(100, c);
    n_checks++; if (result !== 32'd231) begin n_fail++; $display("FAIL three_result got %0d want 231", result); end
    n_checks++; if (n_ops !== 4'd3) begin n_fail++; $display("FAIL three_nops got %0d want 3", n_ops); end
    n_checks++; if (rd_cnt - rd0 !== 3 || ms_cnt - ms0 !== 2) begin n_fail++; $display("FAIL three_strobes got rd=%0d ms=%0d want 3/2", rd_cnt - rd0, ms_cnt - ms0); end
    n_checks++; if (c !== 21) begin n_fail++; $display("FAIL three_latency got %0d want 21", c); end
  endtask

  task automatic test_race();
    int c;
    scanning_e = 1'b1;
    pulse_start();
    push_word(32'd2); push_word(32'd3);
    repeat (25) @(negedge clk);
    push_en = 1'b1; push_data = 32'd9; scanning_e = 1'b0;
    @(negedge clk);
    push_en = 1'b0;
    wait_done(100, c);
    n_checks++; if (result !== 32'd54 || result_valid !== 1'b1) begin n_fail++; $display("FAIL race_result got %0d v=%b want 54 v=1", result, result_valid); end
    n_checks++; if (n_ops !== 4'd3) begin n_fail++; $display("FAIL race_nops got %0d want 3", n_ops); end
  endtask

  task automatic test_restart_mulwait();
    int c; int n; int ms0;
    ms0 = ms_cnt;
    scanning_e = 1'b1;
    pulse_start();
    push_word(32'd100); push_word(32'd200);
    n = 0;
    while (!mul_start && n < 50) begin @(negedge clk); n++; end
    n_checks++; if (mul_start !== 1'b1) begin n_fail++; $display("FAIL flush_mul_start_timeout got %b want 1", mul_start); end
    pulse_start();
    n_checks++; if (busy !== 1'b1 || result_valid !== 1'b0) begin n_fail++; $display("FAIL flush_busy got busy=%b v=%b want 1/0", busy, result_valid); end
    push_word(32'd2); push_word(32'd4);
    scanning_e = 1'b0;
    wait_done(200, c);
    n_checks++; if (result !== 32'd8 || result_valid !== 1'b1) begin n_fail++; $display("FAIL flush_result got %0d v=%b want 8 v=1", result, result_valid); end
    n_checks++; if (n_ops !== 4'd2 || ms_cnt - ms0 !== 2) begin n_fail++; $display("FAIL flush_counts got nops=%0d ms=%0d want 2/2", n_ops, ms_cnt - ms0); end
  endtask

  task automatic test_restart_fetch();
    int c; int n; int rd0;
    scanning_e = 1'b1;
    pulse_start();
    rd0 = rd_cnt;
    push_word(32'd50);
    n = 0;
    while (rd_cnt - rd0 < 1 && n < 20) begin @(negedge clk); n++; end
    pulse_start();
    push_word(32'd3);
    scanning_e = 1'b0;
    wait_done(100, c);
    n_checks++; if (result !== 32'd3 || n_ops !== 4'd1) begin n_fail++; $display("FAIL fetch_restart got %0d nops=%0d want 3 nops=1", result, n_ops); end
  endtask

  task automatic test_saturate();
    int c; int rd0;
    rd0 = rd_cnt;
    scanning_e = 1'b0;
    for (int i = 0; i < 17; i++) push_word(32'd1);
    pulse_start();
    wait_done(1000, c);
    n_checks++; if (result_valid !== 1'b1 || result !== 32'd1) begin n_fail++; $display("FAIL sat_result got %0d v=%b want 1 v=1", result, result_valid); end
    n_checks++; if (n_ops !== 4'd15) begin n_fail++; $display("FAIL sat_nops got %0d want 15", n_ops); end
    n_checks++; if (rd_cnt - rd0 !== 17) begin n_fail++; $display("FAIL sat_reads got %0d want 17", rd_cnt - rd0); end
  endtask

  task automatic test_stray_done();
    int ms0;
    ms0 = ms_cnt;
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || result_valid !== 1'b1 || result !== 32'd1 || ms_cnt - ms0 !== 0) begin n_fail++; $display("FAIL stray_done got busy=%b v=%b r=%0d ms=%0d want 0/1/1/0", busy, result_valid, result, ms_cnt - ms0); end
  endtask

  task automatic test_rst_fetch();
    int n; int rd0; int ms0;
    ms0 = ms_cnt;
    scanning_e = 1'b1;
    pulse_start();
    rd0 = rd_cnt;
    push_word(32'd6); push_word(32'd7);
    n = 0;
    while (rd_cnt - rd0 < 2 && n < 40) begin @(negedge clk); n++; end
    n_checks++; if (rd_cnt - rd0 !== 2) begin n_fail++; $display("FAIL rstfetch_reads got %0d want 2", rd_cnt - rd0); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || n_ops !== '0 || result !== '0) begin n_fail++; $display("FAIL rstfetch_outputs got busy=%b v=%b nops=%0d r=%0d want 0", busy, result_valid, n_ops, result); end
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || n_ops !== '0 || result !== '0) begin n_fail++; $display("FAIL rststale_outputs got busy=%b v=%b nops=%0d r=%0d want 0", busy, result_valid, n_ops, result); end
    n_checks++; if (mul_a !== '0 || mul_b !== '0 || mul_start !== 1'b0 || rd_fifo !== 1'b0 || ms_cnt - ms0 !== 0) begin n_fail++; $display("FAIL rststale_mul got a=%0d b=%0d ms=%b rd=%b starts=%0d want 0", mul_a, mul_b, mul_start, rd_fifo, ms_cnt - ms0); end
  endtask

  task automatic test_protocol();
    n_checks++; if (rd_bad !== 0) begin n_fail++; $display("FAIL rd_while_empty got %0d want 0", rd_bad); end
    n_checks++; if (overlap !== 0) begin n_fail++; $display("FAIL mul_overlap got %0d want 0", overlap); end
    n_checks++; if (lat_bad !== 0) begin n_fail++; $display("FAIL rd_to_start_latency got %0d bad want 0", lat_bad); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_empty();
    test_single();
    test_three();
    test_race();
    test_restart_mulwait();
    test_restart_fetch();
    test_saturate();
    test_stray_done();
    test_rst_fetch();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/me_product_acc.md
ME_PRODUCT_ACC -- requirements
Module: me_product_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 3072, operand/result width in bits.
REQ-002 SHALL have parameter CNT_W, default 13, width of the operand counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en_pre_me  input  1  one-cycle start pulse for a new product.
REQ-006 SHALL have port scanning_e  input  1  high while the upstream scanner may still write the FIFO.
REQ-007 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-008 SHALL have port fifo_dout  input  WIDTH  FIFO read data, valid the cycle after rd_fifo.
REQ-009 SHALL have port rd_fifo  output  1  FIFO read strobe, one pop per high cycle.
REQ-010 SHALL have ports mul_a, mul_b  output  WIDTH each  multiplier operands, stable from mul_start until mul_done.
REQ-011 SHALL have port mul_start  output  1  one-cycle multiply request.
REQ-012 SHALL have ports mul_done  input  1, and mul_res  input  WIDTH  multiplier completion pulse and product.
REQ-013 SHALL have ports result  output  WIDTH, result_valid  output  1, busy  output  1, n_ops  output  CNT_W (operands consumed).

Function
REQ-014 SHALL implement states IDLE, COLLECT, FETCH, MUL_WAIT, FLUSH, DONE; busy high in every state except IDLE and DONE.
REQ-015 IDLE/DONE + en_pre_me -> COLLECT; acc_valid cleared, n_ops cleared, result_valid cleared.
REQ-016 COLLECT with !fifo_empty SHALL assert rd_fifo for exactly one cycle and go to FETCH; rd_fifo never asserted while fifo_empty or outside COLLECT.
REQ-017 FETCH, acc_valid=0: acc <= fifo_dout, acc_valid <= 1, n_ops += 1, -> COLLECT.
REQ-018 FETCH, acc_valid=1: mul_a <= acc, mul_b <= fifo_dout, mul_start pulsed the following cycle, n_ops += 1, -> MUL_WAIT.
REQ-019 MUL_WAIT + mul_done: acc <= mul_res, -> COLLECT; at most one multiply outstanding.
REQ-020 Termination: COLLECT SHALL go to DONE only when fifo_empty=1 and scanning_e=0 in two consecutive COLLECT cycles (guards the scanner-clear / FIFO-write race).
REQ-021 Entry to DONE: result <= acc if acc_valid else WIDTH'd1 (empty exponent); result_valid high from that cycle until next en_pre_me or rst.
REQ-022 n_ops SHALL saturate at 2^CNT_W-1, never wrap.
REQ-023 en_pre_me in COLLECT or FETCH SHALL restart as REQ-015; a word popped in FETCH is discarded.
REQ-024 en_pre_me in MUL_WAIT SHALL go to FLUSH; FLUSH waits for mul_done, discards mul_res, then -> COLLECT with REQ-015 clears.
REQ-025 mul_done outside MUL_WAIT/FLUSH SHALL be ignored.
REQ-026 en_pre_me coincident with mul_done in MUL_WAIT: restart wins, product discarded, -> COLLECT.
REQ-027 Latency: per operand after the first, rd_fifo -> mul_start is 2 cycles; mul_done -> next rd_fifo is 1 cycle if FIFO non-empty.

Reset
REQ-028 rst SHALL force IDLE; rd_fifo, mul_start, result_valid, busy = 0; result, acc, mul_a, mul_b = 0; n_ops = 0; acc_valid = 0.
REQ-029 rst mid-operation (any state incl. MUL_WAIT) SHALL abort immediately; a later stale mul_done SHALL be ignored per REQ-025.

Verification
REQ-030 Empty exponent: en_pre_me, scanning_e=0, fifo_empty=1 -> no rd_fifo, no mul_start, DONE after 2 COLLECT cycles, result=1, n_ops=0.
REQ-031 Single word 5: FIFO holds 5, scanning_e drops -> one rd_fifo, no mul_start, result=5, n_ops=1.
REQ-032 Words 3,7,11 with model multiplier (4-cycle latency) -> two mul_start, result=231, n_ops=3.
REQ-033 Race: scanning_e falls the same cycle the last word (9) lands in FIFO after 2 prior words -> word 9 consumed, result includes 9.
REQ-034 Restart in MUL_WAIT: en_pre_me during multiply -> FLUSH, stale product not in new result; new run of 2,4 gives result=8.
REQ-035 rst asserted in FETCH, then mul_done pulse -> all outputs at reset values, state stays IDLE.
